// File: rtl/lfsr_arbiter_if.sv
// Request/grant bundle for lfsr_arbiter: requests and pause in, one-hot grant,
// grant-stamped random value, raw LFSR state and lockup pulse out.
interface lfsr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic               pause;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [9:0]         rand_out;
  logic [9:0]         lfsr_state;
  logic               lock_err;

  modport master (
    output pause,
    output req,
    input  gnt,
    input  rand_out,
    input  lfsr_state,
    input  lock_err
  );

  modport slave (
    input  pause,
    input  req,
    output gnt,
    output rand_out,
    output lfsr_state,
    output lock_err
  );
endinterface

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter with a post-grant cooldown; each grant carries a 10-bit LFSR sample.
// Build macro LFSR_ARB_LOCKUP_EN enables recovery from the all-ones XNOR lockup state.
//
// state | meaning
// IDLE  | waiting; decision cycle whenever pause=0 and any req is high
// GRANT | single-cycle one-hot grant, rand_out holds the deciding-cycle LFSR value
// COOL  | cooldown down-counter, leaves at terminal count 0
module lfsr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GAP     = 4
) (
  input logic           clk,
  input logic           reset,
  lfsr_arbiter_if.slave bus
);

  localparam int         PTR_W    = $clog2(NUM_REQ);
  localparam logic [3:0] CNT_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("lfsr_arbiter: NUM_REQ must be in 2..8");
  end
  if (GAP < 0 || GAP > 15) begin : g_bad_gap
    $error("lfsr_arbiter: GAP must be in 0..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         lfsr_q, lfsr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [9:0]         rand_q, rand_d;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic               decide;

  // LFSR bits 10..1 map to lfsr_q[9:0]; XNOR feedback makes all-ones the stuck state
`ifdef LFSR_ARB_LOCKUP_EN
  logic lock_hit;
  logic lock_q;

  assign lock_hit = (lfsr_q == 10'h3FF) && !bus.pause;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= lock_hit;
  end

  assign bus.lock_err = lock_q;
`else
  assign bus.lock_err = 1'b0;
`endif

  always_comb begin
    lfsr_d = lfsr_q;
    if (!bus.pause) lfsr_d = {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};
`ifdef LFSR_ARB_LOCKUP_EN
    if (lock_hit) lfsr_d = 10'h000;
`endif
  end

  // search starts at ptr_q and wraps from NUM_REQ-1 back to 0
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && bus.req[idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[PTR_W-1:0];
      end
    end
  end

  assign decide = (state_q == IDLE) && !bus.pause && win_found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (decide) state_d = GRANT;
      GRANT:   state_d = (GAP == 0) ? IDLE : COOL;
      COOL:    if (cnt_q == 4'd0 && !bus.pause) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    rand_d = rand_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    case (state_q)
      IDLE: begin
        if (decide) begin
          gnt_d[win_idx] = 1'b1;
          rand_d         = lfsr_q;
          ptr_d          = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      GRANT: cnt_d = CNT_LOAD;
      COOL: begin
        if (!bus.pause && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= '0;
      cnt_q  <= '0;
      ptr_q  <= '0;
      gnt_q  <= '0;
      rand_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      rand_q <= rand_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rand_out   = rand_q;
  assign bus.lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Scoreboard bench for lfsr_arbiter: expected grants are queued when requests are driven
// and matched against gnt/rand_out/cycle when the grant appears.
`timescale 1ns/1ps
module tb_lfsr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int GAP     = 4;
  localparam int SPACING = GAP + 2;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [9:0]         rnd;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  lfsr_arbiter #(.NUM_REQ(NUM_REQ), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc;
  logic [9:0] m_lfsr;
  bit         lfsr_chk = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], ~(s[9] ^ s[6])};
  endfunction

  function automatic logic [9:0] lfsr_adv(input logic [9:0] s, input int n);
    logic [9:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = lfsr_next(t);
    return t;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc    <= 0;
      m_lfsr <= '0;
    end else begin
      cyc <= cyc + 1;
      if (!bus.pause) m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (lfsr_chk) begin
        check("lfsr_track", bus.lfsr_state, m_lfsr);
        check("lock_err_quiet", bus.lock_err, 0);
      end
      if (sb.size() != 0 && sb[0].cyc < cyc) begin
        check("missed_gnt_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.gnt != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_gnt", bus.gnt, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("gnt", bus.gnt, e.gnt);
          check("rand_out", bus.rand_out, e.rnd);
          check("gnt_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < target) check("goto_timeout", cyc, target);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         n;
    logic [9:0] l;

    reset     = 1'b1;
    bus.pause = 1'b0;
    bus.req   = '0;
    #12;
    check("rst_lfsr", bus.lfsr_state, 0);
    check("rst_rand", bus.rand_out, 0);
    check("rst_gnt", bus.gnt, 0);
    check("rst_lock", bus.lock_err, 0);

    // reset release: fixed first LFSR values
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("lfsr_first", bus.lfsr_state, 10'h001);
    check("gnt_quiet1", bus.gnt, 0);
    @(negedge clk);
    check("lfsr_second", bus.lfsr_state, 10'h003);
    @(negedge clk);
    check("lfsr_third", bus.lfsr_state, 10'h007);
    check("gnt_quiet3", bus.gnt, 0);

    // all lanes held: 0,1,2,3,0 spaced GAP+2 apart
    n = cyc;
    l = m_lfsr;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++)
      sb.push_back('{gnt: NUM_REQ'(1 << (k % NUM_REQ)), rnd: lfsr_adv(l, SPACING * k),
                     cyc: n + 1 + SPACING * k});
    goto(n + 1 + 4 * SPACING);
    bus.req = '0;
    goto(n + 1 + 5 * SPACING + 1);

    // single req[2] pulse, then a request made during COOL starting the search at 3
    n = cyc;
    l = m_lfsr;
    bus.req = 4'b0100;
    sb.push_back('{gnt: 4'b0100, rnd: l, cyc: n + 1});
    @(negedge clk);
    bus.req = '0;
    goto(n + 3);
    bus.req = 4'b1011;
    sb.push_back('{gnt: 4'b1000, rnd: lfsr_adv(l, SPACING), cyc: n + 1 + SPACING});
    goto(n + 1 + SPACING);
    bus.req = '0;

    // a request withdrawn during COOL is never granted
    goto(n + 3 + SPACING);
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = '0;
    goto(n + 20);
    check("sb_drained_withdrawn", sb.size(), 0);

    // pause for 5 cycles mid-COOL delays the next grant by exactly 5
    n = cyc;
    l = m_lfsr;
    bus.req = 4'b0001;
    sb.push_back('{gnt: 4'b0001, rnd: l, cyc: n + 1});
    sb.push_back('{gnt: 4'b0010, rnd: lfsr_adv(l, SPACING), cyc: n + 1 + SPACING + 5});
    @(negedge clk);
    bus.req = '0;
    goto(n + 2);
    bus.req   = 4'b0010;
    bus.pause = 1'b1;
    goto(n + 7);
    check("pause_lfsr_hold", bus.lfsr_state, lfsr_adv(l, 2));
    check("pause_no_gnt", bus.gnt, 0);
    bus.pause = 1'b0;
    goto(n + 1 + SPACING + 5);
    bus.req = '0;

    // reset between edges during GRANT clears outputs immediately
    goto(n + 1 + 2 * SPACING + 5);
    n = cyc;
    l = m_lfsr;
    bus.req = 4'b0100;
    sb.push_back('{gnt: 4'b0100, rnd: l, cyc: n + 1});
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_gnt", bus.gnt, 0);
    check("async_rst_rand", bus.rand_out, 0);
    check("async_rst_lfsr", bus.lfsr_state, 0);
    bus.req = '0;
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b1001;
    sb.push_back('{gnt: 4'b0001, rnd: 10'h000, cyc: 1});
    @(negedge clk);
    bus.req = '0;
    goto(1 + SPACING + 1);
    check("sb_drained_reset", sb.size(), 0);

    // all-ones lockup state
    lfsr_chk = 1'b0;
    @(negedge clk);
    force dut.lfsr_q = 10'h3FF;
    @(posedge clk);
    #1;
    release dut.lfsr_q;
    @(negedge clk);
`ifdef LFSR_ARB_LOCKUP_EN
    check("lock_err_pulse", bus.lock_err, 1);
    @(negedge clk);
    check("lock_err_single", bus.lock_err, 0);
`else
    check("lockup_hold", bus.lfsr_state, 10'h3FF);
    check("lock_err_tied", bus.lock_err, 0);
    @(negedge clk);
    check("lockup_hold2", bus.lfsr_state, 10'h3FF);
    check("lock_err_tied2", bus.lock_err, 0);
`endif

    check("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_arbiter.md
LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (lanes), legal range 2..8.
REQ-002 Parameter GAP, default 4, number of cooldown cycles after each grant, legal range 0..15.
REQ-003 Port clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 Port reset  input  1  is an asynchronous, active-high reset.
REQ-005 Port pause  input  1  freezes the LFSR, the cooldown counter and new grants while high.
REQ-006 Port req  input  NUM_REQ  carries the level request lines; bit i corresponds to requester i.
REQ-007 Port gnt  output  NUM_REQ  is the registered one-hot grant; it pulses for exactly one cycle.
REQ-008 Port rand_out  output  10  is the random value delivered with gnt and held until the next grant.
REQ-009 Port lfsr_state  output  10  exposes the current internal LFSR register.
REQ-010 Port lock_err  output  1  is a one-cycle pulse on lockup recovery (see Configuration).

Function
REQ-011 The internal LFSR is 10 bits wide (bits 10..1); feedback = bit10 XNOR bit7, shifted into bit1, with bit k moving to bit k+1.
REQ-012 The LFSR advances once per cycle whenever pause=0, independent of requests and grants.
REQ-013 The FSM has three states: IDLE, GRANT and COOL; the reset state is IDLE.
REQ-014 IDLE: if pause=0 and any req bit is high at an edge, the FSM moves to GRANT; otherwise it stays in IDLE.
REQ-015 On entry to GRANT: gnt has exactly one bit set, for the winner; rand_out is loaded with the pre-advance LFSR value from the deciding cycle.
REQ-016 Winner selection is round-robin: the search starts at the index after the last winner and wraps from NUM_REQ-1 to 0.
REQ-017 After reset the round-robin pointer gives requester 0 the highest priority.
REQ-018 GRANT lasts one cycle and is not affected by pause.
REQ-019 From GRANT the FSM moves to COOL with the counter loaded to GAP-1; if GAP=0 it moves directly to IDLE.
REQ-020 COOL: the counter decrements once per cycle while pause=0 and holds while pause=1; the FSM moves to IDLE when the counter equals 0.
REQ-021 gnt=0 in every state except GRANT.
REQ-022 Requests that arrive during GRANT or COOL are not lost: they are evaluated on the first IDLE decision cycle.
REQ-023 A requester drops req in the cycle after its gnt; if req is still high, it is treated as a new request.
REQ-024 A req bit that deasserts before the decision cycle receives no grant; no request state is latched.
REQ-025 Grant-to-grant latency under continuous requests is GAP+2 cycles (GRANT, then GAP COOL cycles, then the IDLE decision cycle).

Reset
REQ-026 While reset=1, the outputs are: lfsr_state=0, rand_out=0, gnt=0, lock_err=0, FSM=IDLE, counter=0, pointer=0.
REQ-027 Reset takes effect asynchronously; a reset asserted during GRANT clears gnt without waiting for a clock edge.
REQ-028 After release, the first LFSR advance gives 0x001, then 0x003, then 0x007.

Configuration
REQ-029 Macro LFSR_ARB_LOCKUP_EN controls lockup recovery.
REQ-030 With LFSR_ARB_LOCKUP_EN defined: when lfsr_state=0x3FF and pause=0, the next LFSR value is 0x000 and lock_err pulses high for that cycle.
REQ-031 Without LFSR_ARB_LOCKUP_EN: no lockup detection; the LFSR stays at 0x3FF indefinitely and lock_err is tied to 0.

Verification
REQ-032 Reset release, pause=0, req=0 for 3 cycles -> lfsr_state = 0x001, 0x003, 0x007; gnt stays 0.
REQ-033 req=4'b1111 held, GAP=4 -> grants go to 0,1,2,3,0 in order, spaced 6 cycles apart; each rand_out equals lfsr_state one cycle before its gnt.
REQ-034 Single req[2] pulse while in IDLE -> gnt=4'b0100 for exactly one cycle; the next winner search starts at index 3.
REQ-035 pause=1 for 5 cycles mid-COOL -> counter and lfsr_state hold their values; COOL exit is delayed by exactly 5 cycles; no gnt is issued.
REQ-036 Reset asserted between edges during GRANT -> gnt and rand_out are 0 immediately; after release, the first grant goes to requester 0.
REQ-037 With LFSR_ARB_LOCKUP_EN defined and lfsr_state forced to 0x3FF -> next cycle lfsr_state=0x000 and lock_err=1 for one cycle; without the macro, lfsr_state stays at 0x3FF.
